// File: rtl/sirv_sram_copy_master.sv
// Block mover that masters the 1-cycle SRAM uop cmd/rsp port: copies LEN words src->dst, one txn at a time.
// Optional constant-fill mode is compiled in with `define SIRV_SRAM_COPY_FILL_EN (adds cfg_fill, cfg_pattern).
module sirv_sram_copy_master #(
  parameter int DW     = 32,
  parameter int MW     = 4,
  parameter int AW     = 32,
  parameter int AW_LSB = 2,
  parameter int LW     = 16,
  parameter int USR_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [AW-1:0]     cfg_src,
  input  logic [AW-1:0]     cfg_dst,
  input  logic [LW-1:0]     cfg_len,
`ifdef SIRV_SRAM_COPY_FILL_EN
  input  logic              cfg_fill,
  input  logic [DW-1:0]     cfg_pattern,
`endif
  output logic              busy,
  output logic              done,
  output logic              uop_cmd_valid,
  input  logic              uop_cmd_ready,
  output logic              uop_cmd_read,
  output logic [AW-1:0]     uop_cmd_addr,
  output logic [DW-1:0]     uop_cmd_wdata,
  output logic [MW-1:0]     uop_cmd_wmask,
  output logic [USR_W-1:0]  uop_cmd_usr,
  input  logic              uop_rsp_valid,
  output logic              uop_rsp_ready,
  input  logic [DW-1:0]     uop_rsp_rdata,
  input  logic [USR_W-1:0]  uop_rsp_usr
);

  // Handshakes: a transfer happens on a rising edge where valid && ready; once valid is
  // raised it stays high with a stable payload until accepted. Responses are always accepted.
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_RSP, S_WR_REQ, S_WR_RSP, S_DONE
  } state_e;

  localparam logic [AW-1:0] STRIDE = {{(AW-1){1'b0}}, 1'b1} << AW_LSB;
  localparam logic [LW-1:0] ONE_L  = {{(LW-1){1'b0}}, 1'b1};

  state_e          state_q;
  logic [AW-1:0]   src_q, dst_q;
  logic [DW-1:0]   data_q;
  logic [LW-1:0]   cnt_q;
  logic            cmd_valid_q, cmd_read_q, done_q, cfg_ready_q, busy_q;
`ifdef SIRV_SRAM_COPY_FILL_EN
  logic            fill_q;
`endif

  logic unused_ok;
  assign unused_ok = ^{uop_rsp_usr, cfg_src[AW_LSB-1:0], cfg_dst[AW_LSB-1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      src_q       <= '0;
      dst_q       <= '0;
      data_q      <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      cmd_read_q  <= 1'b0;
      done_q      <= 1'b0;
      cfg_ready_q <= 1'b1;
      busy_q      <= 1'b0;
`ifdef SIRV_SRAM_COPY_FILL_EN
      fill_q      <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cfg_valid) begin
            src_q       <= {cfg_src[AW-1:AW_LSB], {AW_LSB{1'b0}}};
            dst_q       <= {cfg_dst[AW-1:AW_LSB], {AW_LSB{1'b0}}};
            cnt_q       <= cfg_len;
            cfg_ready_q <= 1'b0;
            busy_q      <= 1'b1;
`ifdef SIRV_SRAM_COPY_FILL_EN
            fill_q      <= cfg_fill;
`endif
            if (cfg_len == '0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
`ifdef SIRV_SRAM_COPY_FILL_EN
            end else if (cfg_fill) begin
              data_q      <= cfg_pattern;
              state_q     <= S_WR_REQ;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b0;
`endif
            end else begin
              state_q     <= S_RD_REQ;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b1;
            end
          end
        end
        S_RD_REQ: begin
          if (uop_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_RD_RSP;
          end
        end
        S_RD_RSP: begin
          if (uop_rsp_valid) begin
            data_q      <= uop_rsp_rdata;
            state_q     <= S_WR_REQ;
            cmd_valid_q <= 1'b1;
            cmd_read_q  <= 1'b0;
          end
        end
        S_WR_REQ: begin
          if (uop_cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= S_WR_RSP;
          end
        end
        S_WR_RSP: begin
          if (uop_rsp_valid) begin
            src_q <= src_q + STRIDE;
            dst_q <= dst_q + STRIDE;
            cnt_q <= cnt_q - ONE_L;
            if (cnt_q == ONE_L) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
`ifdef SIRV_SRAM_COPY_FILL_EN
            end else if (fill_q) begin
              state_q     <= S_WR_REQ;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b0;
`endif
            end else begin
              state_q     <= S_RD_REQ;
              cmd_valid_q <= 1'b1;
              cmd_read_q  <= 1'b1;
            end
          end
        end
        S_DONE: begin
          state_q     <= S_IDLE;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        default: begin
          state_q     <= S_IDLE;
          cmd_valid_q <= 1'b0;
          cfg_ready_q <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Address is a mux of two registers that only move in WR_RSP, so it is stable while a request waits.
  assign uop_cmd_addr  = cmd_read_q ? src_q : dst_q;
  assign uop_cmd_wdata = data_q;
  assign uop_cmd_wmask = '1;
  assign uop_cmd_valid = cmd_valid_q;
  assign uop_cmd_read  = cmd_read_q;
  assign uop_rsp_ready = 1'b1;
  assign cfg_ready     = cfg_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;

  always_comb begin
    uop_cmd_usr    = '0;
    uop_cmd_usr[0] = cmd_read_q;
  end

endmodule

// File: tb/tb_sirv_sram_copy_master.sv
// Bench for sirv_sram_copy_master: SRAM responder with 1-cycle responses, per-job expected txn queue.
// Define SIRV_SRAM_COPY_FILL_EN to also exercise the constant-fill mode.
module tb_sirv_sram_copy_master;

  localparam int W = 65;

  logic        clk, rst;
  logic        cfg_valid, cfg_ready;
  logic [31:0] cfg_src, cfg_dst;
  logic [15:0] cfg_len;
`ifdef SIRV_SRAM_COPY_FILL_EN
  logic        cfg_fill;
  logic [31:0] cfg_pattern;
`endif
  logic        busy, done;
  logic        uop_cmd_valid, uop_cmd_ready, uop_cmd_read;
  logic [31:0] uop_cmd_addr, uop_cmd_wdata;
  logic [3:0]  uop_cmd_wmask;
  logic [2:0]  uop_cmd_usr;
  logic        uop_rsp_valid, uop_rsp_ready;
  logic [31:0] uop_rsp_rdata;
  logic [2:0]  uop_rsp_usr;

  sirv_sram_copy_master dut (
    .clk(clk), .rst(rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
`ifdef SIRV_SRAM_COPY_FILL_EN
    .cfg_fill(cfg_fill), .cfg_pattern(cfg_pattern),
`endif
    .busy(busy), .done(done),
    .uop_cmd_valid(uop_cmd_valid), .uop_cmd_ready(uop_cmd_ready),
    .uop_cmd_read(uop_cmd_read), .uop_cmd_addr(uop_cmd_addr),
    .uop_cmd_wdata(uop_cmd_wdata), .uop_cmd_wmask(uop_cmd_wmask),
    .uop_cmd_usr(uop_cmd_usr),
    .uop_rsp_valid(uop_rsp_valid), .uop_rsp_ready(uop_rsp_ready),
    .uop_rsp_rdata(uop_rsp_rdata), .uop_rsp_usr(uop_rsp_usr)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          checks = 0;
  int          failures = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  logic [31:0] seed;
  bit          stall_mode = 0;
  bit          noise_mode = 0;
  int          done_cnt = 0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  function automatic logic [W-1:0] mk(input logic rd, input logic [31:0] a, input logic [31:0] d);
    return {rd, a, d};
  endfunction

  // ---------------- SRAM responder + monitor ----------------
  logic        pend;
  logic [31:0] pend_data;
  logic        stalled;
  logic [W-1:0] stall_payload;

  initial begin
    pend = 0; pend_data = '0; stalled = 0; stall_payload = '0;
    uop_rsp_valid = 0; uop_rsp_rdata = '0; uop_rsp_usr = '0; uop_cmd_ready = 1;
  end

  always @(negedge clk) begin
    if (rst) begin
      uop_rsp_valid = 0;
      pend = 0;
      stalled = 0;
    end else begin
      uop_rsp_valid = pend | (noise_mode && !pend && $urandom_range(0, 3) == 0);
      uop_rsp_rdata = pend ? pend_data : $urandom;
      uop_rsp_usr   = 3'($urandom_range(0, 7));
      pend = 0;
      if (stalled) begin
        check("stall_valid_held", {64'd0, uop_cmd_valid}, {64'd0, 1'b1});
        check("stall_payload", {uop_cmd_read, uop_cmd_addr, uop_cmd_wdata}, stall_payload);
      end
      uop_cmd_ready = stall_mode ? 1'($urandom_range(0, 1)) : 1'b1;
      if (uop_cmd_valid && uop_cmd_ready) begin
        obs_q.push_back(mk(uop_cmd_read, uop_cmd_addr, uop_cmd_read ? 32'h0 : uop_cmd_wdata));
        check("cmd_usr", {62'd0, uop_cmd_usr}, {62'd0, 2'b00, uop_cmd_read});
        check("cmd_wmask", {61'd0, uop_cmd_wmask}, {61'd0, 4'hF});
        pend = 1;
        pend_data = mem_f(uop_cmd_addr);
      end
      stalled = uop_cmd_valid && !uop_cmd_ready;
      stall_payload = {uop_cmd_read, uop_cmd_addr, uop_cmd_wdata};
      if (done) done_cnt++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic start_cfg(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] len,
                           input bit fill, input logic [31:0] pat);
    @(negedge clk); #1;
    check("cfg_ready_before_accept", {64'd0, cfg_ready}, {64'd0, 1'b1});
    cfg_valid = 1; cfg_src = src; cfg_dst = dst; cfg_len = len;
`ifdef SIRV_SRAM_COPY_FILL_EN
    cfg_fill = fill; cfg_pattern = pat;
`else
    if (fill || pat != 32'h0) $display("note: fill mode not compiled in");
`endif
    @(posedge clk); #1;
    cfg_valid = 0; cfg_src = $urandom; cfg_dst = $urandom; cfg_len = 16'($urandom);
  endtask

  task automatic run_job(input string name, input logic [31:0] src, input logic [31:0] dst,
                         input logic [15:0] len, input bit fill, input logic [31:0] pat,
                         input int exp_cyc, input bit poke);
    logic [31:0] s, d;
    int k;
    s = src & ~32'h3;
    d = dst & ~32'h3;
    exp_q.delete();
    for (int i = 0; i < int'(len); i++) begin
      if (!fill) exp_q.push_back(mk(1'b1, s, 32'h0));
      exp_q.push_back(mk(1'b0, d, fill ? pat : mem_f(s)));
      s += 32'd4;
      d += 32'd4;
    end
    obs_q.delete();
    done_cnt = 0;
    start_cfg(src, dst, len, fill, pat);
    k = 0;
    while (k < 3000) begin
      @(negedge clk); #1;
      k++;
      if (k == 1)
        check({name, "_busy_cfg_ready"}, {63'd0, busy, cfg_ready}, {63'd0, 2'b10});
      if (done) begin
        cfg_valid = 0;
        break;
      end
      if (poke && k >= 2) begin
        cfg_valid = 1; cfg_src = $urandom; cfg_dst = $urandom; cfg_len = 16'($urandom_range(1, 9));
      end
    end
    cfg_valid = 0;
    check({name, "_done_seen"}, {64'd0, done}, {64'd0, 1'b1});
    if (exp_cyc > 0) check({name, "_done_cycle"}, W'(k), W'(exp_cyc));
    @(negedge clk); #1;
    check({name, "_after_done"}, {62'd0, done, busy, cfg_ready}, {62'd0, 3'b001});
    check({name, "_done_pulses"}, W'(done_cnt), W'(1));
    check({name, "_txn_count"}, W'(obs_q.size()), W'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("%s_txn%0d", name, i), (i < obs_q.size()) ? obs_q[i] : '1, exp_q[i]);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [31:0] rs, rd;
    int ln;
    seed = $urandom;
    rst = 1; cfg_valid = 0; cfg_src = '0; cfg_dst = '0; cfg_len = '0;
`ifdef SIRV_SRAM_COPY_FILL_EN
    cfg_fill = 0; cfg_pattern = '0;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_ctrl", {59'd0, cfg_ready, busy, done, uop_cmd_valid, uop_rsp_ready, uop_cmd_read},
          {59'd0, 6'b100010});
    check("rst_payload", {1'b0, uop_cmd_addr, uop_cmd_wdata}, '0);
    @(negedge clk); #1 rst = 0;

    run_job("copy4", 32'h100, 32'h200, 16'd4, 0, 32'h0, 17, 0);
    run_job("len0", 32'h300, 32'h400, 16'd0, 0, 32'h0, 1, 0);

    stall_mode = 1; noise_mode = 1;
    run_job("stall8", 32'h0001_0000 + ($urandom_range(0, 255) << 2), 32'h0002_0000, 16'd8, 0, 32'h0, 0, 1);
    stall_mode = 0; noise_mode = 0;

    run_job("wrap", 32'hFFFF_FFFC, 32'h0000_1002, 16'd2, 0, 32'h0, 9, 0);

    // Reset while the second word's write request is outstanding.
    obs_q.delete();
    done_cnt = 0;
    start_cfg(32'h500, 32'h600, 16'd4, 0, 32'h0);
    ln = 0;
    while (ln < 200 && !(uop_cmd_valid && !uop_cmd_read && uop_cmd_addr == 32'h604)) begin
      @(negedge clk); #2;
      ln++;
    end
    check("rst_mid_reached_wr2", W'(ln < 200), W'(1));
    rst = 1;
    #1;
    check("rst_mid_async", {61'd0, uop_cmd_valid, busy, done, cfg_ready}, {61'd0, 4'b0001});
    repeat (2) @(negedge clk);
    #2 rst = 0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mid_no_done", W'(done_cnt), W'(0));
    ln = $urandom_range(1, 5);
    run_job("post_rst", 32'h700, 32'h800, 16'(ln), 0, 32'h0, 4 * ln + 1, 0);

    for (int j = 0; j < 3; j++) begin
      rs = $urandom; rd = $urandom;
      ln = $urandom_range(1, 6);
      stall_mode = 1'($urandom_range(0, 1));
      noise_mode = 1;
      run_job($sformatf("rand%0d", j), rs, rd, 16'(ln), 0, 32'h0, stall_mode ? 0 : 4 * ln + 1, 0);
    end
    stall_mode = 0; noise_mode = 0;

`ifdef SIRV_SRAM_COPY_FILL_EN
    run_job("fill3", 32'h1234_5678, 32'h40, 16'd3, 1, 32'hDEAD_BEEF, 7, 0);
    stall_mode = 1;
    run_job("fill_stall", 32'h0, 32'h80, 16'd4, 1, $urandom, 0, 0);
    stall_mode = 0;
    run_job("fill0_copy", 32'h900, 32'hA00, 16'd2, 0, 32'h0, 9, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
